// File: rtl/decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered RV32I(+M) decoder with a valid/ready handshake, flush
//            and an interlock that holds M operations while the MDU is busy.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int ENABLE_M   = 1,
    parameter int ALU_CTRL_W = 4,
    parameter int PC_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [PC_W-1:0]       in_pc,
    input  logic                  flush,
    input  logic                  mdu_busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_W-1:0]       out_pc,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic                  branch,
    output logic                  jump,
    output logic                  jalr,
    output logic                  alu_src,
    output logic                  alu_src_a,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            result_src,
    output logic [2:0]            imm_src,
    output logic [2:0]            addressing_control,
    output logic                  mdu_en,
    output logic [2:0]            mdu_op,
    output logic                  illegal
);

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_fence  = 7'b0001111;

    localparam logic [6:0] c_f7_base   = 7'b0000000;
    localparam logic [6:0] c_f7_alt    = 7'b0100000;
    localparam logic [6:0] c_f7_muldiv = 7'b0000001;

    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_and  = 4'b0010;
    localparam logic [3:0] c_alu_or   = 4'b0011;
    localparam logic [3:0] c_alu_xor  = 4'b0100;
    localparam logic [3:0] c_alu_slt  = 4'b0101;
    localparam logic [3:0] c_alu_sltu = 4'b0110;
    localparam logic [3:0] c_alu_sll  = 4'b0111;
    localparam logic [3:0] c_alu_srl  = 4'b1000;
    localparam logic [3:0] c_alu_sra  = 4'b1011;
    localparam logic [3:0] c_alu_lui  = 4'b1111;
    localparam logic [3:0] c_alu_bne  = 4'b1100;
    localparam logic [3:0] c_alu_bge  = 4'b1001;
    localparam logic [3:0] c_alu_bgeu = 4'b1010;

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic                  reg_write;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  jalr;
        logic                  alu_src;
        logic                  alu_src_a;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic [1:0]            result_src;
        logic [2:0]            imm_src;
        logic [2:0]            addressing_control;
        logic                  mdu_en;
        logic [2:0]            mdu_op;
        logic                  illegal;
    } bundle_t;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [3:0] w_alu;
    bundle_t    w_dec;
    bundle_t    r_bundle;
    logic       r_v;
    logic       w_stall_mdu;
    logic       w_in_ready;
    logic       w_fire;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];

    // Shared by R-type and I-ALU; alt selects SUB/SRA.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = c_alu_add;
        case (f3)
            3'b000:  op = alt ? c_alu_sub : c_alu_add;
            3'b001:  op = c_alu_sll;
            3'b010:  op = c_alu_slt;
            3'b011:  op = c_alu_sltu;
            3'b100:  op = c_alu_xor;
            3'b101:  op = alt ? c_alu_sra : c_alu_srl;
            3'b110:  op = c_alu_or;
            default: op = c_alu_and;
        endcase
        return op;
    endfunction

    always_comb begin
        w_dec     = '0;
        w_alu     = c_alu_add;
        w_dec.pc  = in_pc;
        w_dec.rd  = in_instr[11:7];
        w_dec.rs1 = in_instr[19:15];
        w_dec.rs2 = in_instr[24:20];
        case (w_opcode)
            c_op_r: begin
                if ((ENABLE_M != 0) && (w_funct7 == c_f7_muldiv)) begin
                    w_dec.reg_write  = 1'b1;
                    w_dec.mdu_en     = 1'b1;
                    w_dec.mdu_op     = w_funct3;
                    w_dec.result_src = 2'b11;
                end else if ((w_funct7 == c_f7_base) ||
                             ((w_funct7 == c_f7_alt) &&
                              ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))) begin
                    w_dec.reg_write = 1'b1;
                    w_alu           = alu_op(w_funct3, w_funct7[5]);
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            c_op_imm: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_alu           = alu_op(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                if ((w_funct3 == 3'b001) && (w_funct7 != c_f7_base))
                    w_dec.illegal = 1'b1;
                if ((w_funct3 == 3'b101) && (w_funct7 != c_f7_base) && (w_funct7 != c_f7_alt))
                    w_dec.illegal = 1'b1;
            end
            c_op_load: begin
                w_dec.reg_write          = 1'b1;
                w_dec.alu_src            = 1'b1;
                w_dec.result_src         = 2'b01;
                w_dec.addressing_control = w_funct3;
                if ((w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111))
                    w_dec.illegal = 1'b1;
            end
            c_op_store: begin
                w_dec.mem_write          = 1'b1;
                w_dec.alu_src            = 1'b1;
                w_dec.imm_src            = 3'b001;
                w_dec.addressing_control = w_funct3;
                if (w_funct3 >= 3'b011)
                    w_dec.illegal = 1'b1;
            end
            c_op_branch: begin
                w_dec.branch  = 1'b1;
                w_dec.imm_src = 3'b010;
                case (w_funct3)
                    3'b000:  w_alu = c_alu_sub;
                    3'b001:  w_alu = c_alu_bne;
                    3'b100:  w_alu = c_alu_slt;
                    3'b101:  w_alu = c_alu_bge;
                    3'b110:  w_alu = c_alu_sltu;
                    3'b111:  w_alu = c_alu_bgeu;
                    default: w_dec.illegal = 1'b1;
                endcase
            end
            c_op_jal: begin
                w_dec.reg_write  = 1'b1;
                w_dec.jump       = 1'b1;
                w_dec.imm_src    = 3'b011;
                w_dec.result_src = 2'b10;
            end
            c_op_jalr: begin
                w_dec.reg_write  = 1'b1;
                w_dec.jalr       = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = 2'b10;
                if (w_funct3 != 3'b000)
                    w_dec.illegal = 1'b1;
            end
            c_op_lui: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.imm_src   = 3'b100;
                w_alu           = c_alu_lui;
            end
            c_op_auipc: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_src_a = 1'b1;
                w_dec.imm_src   = 3'b100;
            end
            c_op_fence: begin
                w_dec.illegal = 1'b0;
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
        // Illegal words still travel with their PC, but must not cause side effects.
        if (w_dec.illegal) begin
            w_dec.reg_write = 1'b0;
            w_dec.mem_write = 1'b0;
            w_dec.branch    = 1'b0;
            w_dec.jump      = 1'b0;
            w_dec.jalr      = 1'b0;
            w_dec.mdu_en    = 1'b0;
        end
        w_dec.alu_control = ALU_CTRL_W'(w_alu);
    end

    assign w_stall_mdu = r_v & r_bundle.mdu_en & mdu_busy;
    assign out_valid   = r_v & ~w_stall_mdu;
    assign w_in_ready  = ~r_v | (out_ready & ~w_stall_mdu) | flush;
    assign in_ready    = w_in_ready;
    assign w_fire      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v      <= 1'b0;
            r_bundle <= '0;
        end else if (flush) begin
            r_v <= 1'b0;
        end else if (in_valid && w_in_ready) begin
            r_v      <= 1'b1;
            r_bundle <= w_dec;
        end else if (w_fire) begin
            r_v <= 1'b0;
        end
    end

    assign out_pc             = r_bundle.pc;
    assign out_rd             = r_bundle.rd;
    assign out_rs1            = r_bundle.rs1;
    assign out_rs2            = r_bundle.rs2;
    assign reg_write          = r_bundle.reg_write;
    assign mem_write          = r_bundle.mem_write;
    assign branch             = r_bundle.branch;
    assign jump               = r_bundle.jump;
    assign jalr               = r_bundle.jalr;
    assign alu_src            = r_bundle.alu_src;
    assign alu_src_a          = r_bundle.alu_src_a;
    assign alu_control        = r_bundle.alu_control;
    assign result_src         = r_bundle.result_src;
    assign imm_src            = r_bundle.imm_src;
    assign addressing_control = r_bundle.addressing_control;
    assign mdu_en             = r_bundle.mdu_en;
    assign mdu_op             = r_bundle.mdu_op;
    assign illegal            = r_bundle.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Scoreboard bench for decode_stage (ENABLE_M=1 and ENABLE_M=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic [6:0] s;      // reg_write, mem_write, branch, jump, jalr, alu_src, alu_src_a
        logic [3:0] alu;
        logic [1:0] rs;
        logic [2:0] imm;
        logic [2:0] ac;
        logic       me;
        logic [2:0] mop;
        logic       ill;
    } ctl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        ctl_t        ctl;
    } exp_t;

    typedef struct {
        exp_t e;
        bit   so;   // only strobes, mdu_en and illegal are defined
    } sb_t;

    typedef struct {
        logic [31:0] instr;
        ctl_t        ctl;
        bit          so;
    } vec_t;

    localparam logic [23:0] c_so_mask = {7'b1111100, 4'h0, 2'b00, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, mdu_busy = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] in_instr = '0, in_pc = '0, out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        reg_write, mem_write, branch, jump, jalr, alu_src, alu_src_a, mdu_en, illegal;
    logic [3:0]  alu_control;
    logic [1:0]  result_src;
    logic [2:0]  imm_src, addressing_control, mdu_op;

    logic        n_in_valid = 1'b0, n_in_ready, n_out_valid;
    logic [31:0] n_in_instr = '0, n_out_pc;
    logic [4:0]  n_rd, n_rs1, n_rs2;
    logic        n_reg_write, n_mem_write, n_branch, n_jump, n_jalr, n_alu_src, n_alu_src_a;
    logic        n_mdu_en, n_illegal;
    logic [3:0]  n_alu_control;
    logic [1:0]  n_result_src;
    logic [2:0]  n_imm_src, n_addressing_control, n_mdu_op;

    int   checks = 0;
    int   errors = 0;
    sb_t  sbq[$];
    sb_t  cur;
    vec_t vecs[$];
    logic [31:0] pc = 32'h0000_1000;
    logic [31:0] held_pc;

    always #5 clk = ~clk;

    decode_stage #(.ENABLE_M(1), .ALU_CTRL_W(4), .PC_W(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .mdu_busy(mdu_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .reg_write(reg_write), .mem_write(mem_write), .branch(branch), .jump(jump),
        .jalr(jalr), .alu_src(alu_src), .alu_src_a(alu_src_a), .alu_control(alu_control),
        .result_src(result_src), .imm_src(imm_src), .addressing_control(addressing_control),
        .mdu_en(mdu_en), .mdu_op(mdu_op), .illegal(illegal)
    );

    decode_stage #(.ENABLE_M(0), .ALU_CTRL_W(4), .PC_W(32)) u_dut_nom (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_instr(n_in_instr), .in_pc(32'h0000_2000), .flush(1'b0), .mdu_busy(1'b1),
        .out_valid(n_out_valid), .out_ready(1'b1), .out_pc(n_out_pc),
        .out_rd(n_rd), .out_rs1(n_rs1), .out_rs2(n_rs2),
        .reg_write(n_reg_write), .mem_write(n_mem_write), .branch(n_branch), .jump(n_jump),
        .jalr(n_jalr), .alu_src(n_alu_src), .alu_src_a(n_alu_src_a), .alu_control(n_alu_control),
        .result_src(n_result_src), .imm_src(n_imm_src), .addressing_control(n_addressing_control),
        .mdu_en(n_mdu_en), .mdu_op(n_mdu_op), .illegal(n_illegal)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ctl_t c(input logic [6:0] s, input logic [3:0] alu, input logic [1:0] rs,
                               input logic [2:0] imm, input logic [2:0] ac, input logic me,
                               input logic [2:0] mop, input logic ill);
        ctl_t r;
        r = {s, alu, rs, imm, ac, me, mop, ill};
        return r;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.pc  = out_pc;
        o.rd  = out_rd;
        o.rs1 = out_rs1;
        o.rs2 = out_rs2;
        o.ctl = {reg_write, mem_write, branch, jump, jalr, alu_src, alu_src_a, alu_control,
                 result_src, imm_src, addressing_control, mdu_en, mdu_op, illegal};
        return o;
    endfunction

    task automatic add(input logic [31:0] instr, input ctl_t ct, input bit so);
        vec_t v;
        v.instr = instr;
        v.ctl   = ct;
        v.so    = so;
        vecs.push_back(v);
    endtask

    task automatic offer(input logic [31:0] instr, input ctl_t ct, input bit so);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_pc      = pc;
        cur.e.pc   = pc;
        cur.e.rd   = instr[11:7];
        cur.e.rs1  = instr[19:15];
        cur.e.rs2  = instr[24:20];
        cur.e.ctl  = ct;
        cur.so     = so;
        pc         = pc + 32'd4;
    endtask

    task automatic send(input vec_t v, input bit bp);
        bit got;
        got = 1'b0;
        offer(v.instr, v.ctl, v.so);
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (bp) out_ready = 1'($urandom_range(0, 1));
        end
        if (!got) check("accept_timeout", 96'(0), 96'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sbq.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 96'(sbq.size()), 96'(0));
    endtask

    // Scoreboard: compare the head while presented, retire on fire, enqueue on accept.
    always @(negedge clk) begin
        if (rst || flush) begin
            sbq.delete();
        end else begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_valid", 96'(1), 96'(0));
                end else begin
                    exp_t o, e, m;
                    o = observe();
                    e = sbq[0].e;
                    m = sbq[0].so ? {32'hFFFF_FFFF, 15'h7FFF, c_so_mask} : '1;
                    check("bundle", 96'(o & m), 96'(e & m));
                    if (out_ready) void'(sbq.pop_front());
                end
            end
            if (in_valid && in_ready) sbq.push_back(cur);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        add(32'h00500093, c(7'b1000010, 4'h0, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0), 1'b0); // addi
        add(32'h402081B3, c(7'b1000000, 4'h1, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0), 1'b0); // sub
        add(32'h12345097, c(7'b1000011, 4'h0, 2'b00, 3'b100, 3'b000, 1'b0, 3'b000, 1'b0), 1'b0); // auipc
        add(32'hFFFFFFFF, c(7'b0000000, 4'h0, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1), 1'b1);
        add(32'h027302B3, c(7'b1000000, 4'h0, 2'b11, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0), 1'b0); // mul
        add(32'h0000A103, c(7'b1000010, 4'h0, 2'b01, 3'b000, 3'b010, 1'b0, 3'b000, 1'b0), 1'b0); // lw
        add(32'h0020A223, c(7'b0100010, 4'h0, 2'b00, 3'b001, 3'b010, 1'b0, 3'b000, 1'b0), 1'b0); // sw
        add(32'h00208463, c(7'b0010000, 4'h1, 2'b00, 3'b010, 3'b000, 1'b0, 3'b000, 1'b0), 1'b0); // beq
        add(32'h0020D463, c(7'b0010000, 4'h9, 2'b00, 3'b010, 3'b000, 1'b0, 3'b000, 1'b0), 1'b0); // bge
        add(32'h000000EF, c(7'b1001000, 4'h0, 2'b10, 3'b011, 3'b000, 1'b0, 3'b000, 1'b0), 1'b1); // jal
        add(32'h123452B7, c(7'b1000010, 4'hF, 2'b00, 3'b100, 3'b000, 1'b0, 3'b000, 1'b0), 1'b0); // lui
        add(32'h4010D093, c(7'b1000010, 4'hB, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0), 1'b0); // srai
        add(32'h0020C233, c(7'b1000000, 4'h4, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0), 1'b0); // xor
        add(32'h0000000F, c(7'b0000000, 4'h0, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0), 1'b1); // fence
        add(32'h40109093, c(7'b0000000, 4'h0, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1), 1'b1); // slli f7
        add(32'h0020A463, c(7'b0000000, 4'h0, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1), 1'b1); // br f3=010
        add(32'h40209233, c(7'b0000000, 4'h0, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1), 1'b1); // sll f7
        add(32'h0000B103, c(7'b0000000, 4'h0, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1), 1'b1); // ld
        add(32'h0020B223, c(7'b0000000, 4'h0, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1), 1'b1); // sd
        add(32'h000090E7, c(7'b0000000, 4'h0, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1), 1'b1); // jalr f3
        add(32'h00000073, c(7'b0000000, 4'h0, 2'b00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1), 1'b1); // ecall

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_in_ready", 96'(in_ready), 96'(1));
        check("rst_bundle", 96'(observe()), 96'(0));
        check("rst_nom_valid", 96'(n_out_valid), 96'(0));

        // Back-to-back with 1-cycle latency
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        offer(vecs[0].instr, vecs[0].ctl, vecs[0].so);
        @(posedge clk);
        #1;
        offer(vecs[1].instr, vecs[1].ctl, vecs[1].so);
        @(negedge clk);
        check("b2b_first_valid", 96'(out_valid), 96'(1));
        check("b2b_first_rd", 96'(out_rd), 96'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_valid", 96'(out_valid), 96'(1));
        check("b2b_second_rd", 96'(out_rd), 96'(3));
        check("b2b_second_alu", 96'(alu_control), 96'(1));
        drain();

        // Whole table at full rate, then under random backpressure
        foreach (vecs[i]) send(vecs[i], 1'b0);
        drain();
        foreach (vecs[i]) send(vecs[i], 1'b1);
        drain();

        // MDU interlock: div held while busy, next instruction follows
        mdu_busy = 1'b1;
        send('{32'h023140B3, c(7'b1000000, 4'h0, 2'b11, 3'b000, 3'b000, 1'b1, 3'b100, 1'b0), 1'b0}, 1'b0);
        offer(vecs[1].instr, vecs[1].ctl, vecs[1].so);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_out_valid", 96'(out_valid), 96'(0));
            check("stall_in_ready", 96'(in_ready), 96'(0));
            @(posedge clk);
            #1;
        end
        mdu_busy = 1'b0;
        @(negedge clk);
        check("mdu_issue_valid", 96'(out_valid), 96'(1));
        check("mdu_issue_op", 96'(mdu_op), 96'(4));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mdu_next_valid", 96'(out_valid), 96'(1));
        check("mdu_next_rd", 96'(out_rd), 96'(3));
        drain();

        // Backpressure then flush with a new offer
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        held_pc = pc;
        offer(vecs[2].instr, vecs[2].ctl, vecs[2].so);
        @(posedge clk);
        #1;
        offer(vecs[1].instr, vecs[1].ctl, vecs[1].so);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_in_ready", 96'(in_ready), 96'(0));
            check("bp_out_valid", 96'(out_valid), 96'(1));
            check("bp_pc_stable", 96'(out_pc), 96'(held_pc));
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 96'(out_valid), 96'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_no_present", 96'(out_valid), 96'(0));
        check("flush_sb_empty", 96'(sbq.size()), 96'(0));

        // ENABLE_M=0: mul is illegal and never stalls on mdu_busy
        @(posedge clk);
        #1;
        n_in_valid = 1'b1;
        n_in_instr = 32'h027302B3;
        @(posedge clk);
        #1;
        n_in_instr = 32'h402081B3;
        @(negedge clk);
        check("nom_mul_valid", 96'(n_out_valid), 96'(1));
        check("nom_mul_illegal", 96'(n_illegal), 96'(1));
        check("nom_mul_strobes", 96'({n_reg_write, n_mem_write, n_branch, n_jump, n_jalr, n_mdu_en}), 96'(0));
        check("nom_mul_pc", 96'(n_out_pc), 96'(32'h0000_2000));
        @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        @(negedge clk);
        check("nom_sub_valid", 96'(n_out_valid), 96'(1));
        check("nom_sub_illegal", 96'(n_illegal), 96'(0));
        check("nom_sub_ctl", 96'({n_reg_write, n_alu_control, n_rd}), 96'({1'b1, 4'h1, 5'd3}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
